alu_wb_stage: RTL and testbench

//  Stage directly downstream of alu_16bit: captures ALU_OUT and N/Z/C/V with sideband
//  (dest reg, write enable, set-flags, branch cond), keeps architectural flags register,

---
 rtl/alu_wb_pkg.sv | 29 ++
 rtl/alu_cond_eval.sv | 32 +++
 rtl/alu_wb_stage.sv | 116 +++++++++++
 tb/tb_alu_wb_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU writeback stage: condition codes, flag bit positions
// and the default-width result entry carried from the ALU to register-file writeback.
package alu_wb_pkg;

   localparam logic [2:0] COND_AL = 3'b000;
   localparam logic [2:0] COND_EQ = 3'b001;
   localparam logic [2:0] COND_NE = 3'b010;
   localparam logic [2:0] COND_LT = 3'b011;
   localparam logic [2:0] COND_GE = 3'b100;
   localparam logic [2:0] COND_CS = 3'b101;
   localparam logic [2:0] COND_CC = 3'b110;
   localparam logic [2:0] COND_MI = 3'b111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int WB_DATA_W = 16;
   localparam int WB_ADDR_W = 3;

   typedef struct packed {
      logic [WB_DATA_W-1:0] data;
      logic [WB_ADDR_W-1:0] addr;
      logic                 we;
      logic                 br_taken;
   } wb_entry_t;

endpackage

// File: rtl/alu_cond_eval.sv
// Condition-code evaluator: {N,Z,C,V} flags and 3-bit condition -> condition true.
// Purely combinational, no handshake.
module alu_cond_eval
   import alu_wb_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [2:0] cond,
   output logic       cond_true
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      cond_true = 1'b1;
      case (cond)
         COND_AL: cond_true = 1'b1;
         COND_EQ: cond_true = z;
         COND_NE: cond_true = ~z;
         COND_LT: cond_true = n ^ v;
         COND_GE: cond_true = ~(n ^ v);
         COND_CS: cond_true = c;
         COND_CC: cond_true = ~c;
         COND_MI: cond_true = n;
      endcase
   end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: flags register, branch resolution at accept, DEPTH-entry result FIFO.
// Latency 1 cycle via FIFO; 0 cycles into an empty FIFO when ALU_WB_BYPASS_EN is defined.
// IN_READY = !full from the registered count; head holds on WB_* until WB_READY.
module alu_wb_stage
   import alu_wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W,
   parameter int DEPTH  = 2
)
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [DATA_W-1:0] ALU_OUT,
   input  logic [3:0]        ALU_FLAGS,
   input  logic [ADDR_W-1:0] RD_ADDR,
   input  logic              RD_WE,
   input  logic              SET_FLAGS,
   input  logic              IS_BRANCH,
   input  logic [2:0]        COND,
   output logic              WB_VALID,
   input  logic              WB_READY,
   output logic [DATA_W-1:0] WB_DATA,
   output logic [ADDR_W-1:0] WB_ADDR,
   output logic              WB_WE,
   output logic              BR_TAKEN,
   output logic [3:0]        FLAGS
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic              br_taken;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           in_entry;
   entry_t           head;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic [3:0]       flags_q;
   logic [3:0]       eval_flags;
   logic             cond_true;
   logic             empty, accept, pop, push, fifo_pop, bypass;

   // New flags from the same op win, so SET_FLAGS branches test their own result.
   assign eval_flags = SET_FLAGS ? ALU_FLAGS : flags_q;

   alu_cond_eval u_cond_eval (
      .flags     (eval_flags),
      .cond      (COND),
      .cond_true (cond_true)
   );

   assign in_entry.data     = ALU_OUT;
   assign in_entry.addr     = RD_ADDR;
   assign in_entry.we       = RD_WE & ~IS_BRANCH;
   assign in_entry.br_taken = IS_BRANCH & cond_true;

   assign empty    = (count == '0);
   assign IN_READY = (count != CNT_W'(DEPTH));
   assign accept   = IN_VALID & IN_READY;

`ifdef ALU_WB_BYPASS_EN
   assign bypass   = empty & IN_VALID & WB_READY;
   assign head     = empty ? in_entry : mem[rd_ptr];
   assign WB_VALID = ~empty | IN_VALID;
`else
   assign bypass   = 1'b0;
   assign head     = mem[rd_ptr];
   assign WB_VALID = ~empty;
`endif

   assign pop      = WB_VALID & WB_READY;
   assign push     = accept & ~bypass;
   assign fifo_pop = pop & ~empty;

   assign WB_DATA  = WB_VALID ? head.data     : '0;
   assign WB_ADDR  = WB_VALID ? head.addr     : '0;
   assign WB_WE    = WB_VALID & head.we;
   assign BR_TAKEN = WB_VALID & head.br_taken;
   assign FLAGS    = flags_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         flags_q <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (fifo_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !fifo_pop)
            count <= count + CNT_W'(1);
         else if (!push && fifo_pop)
            count <= count - CNT_W'(1);
         if (accept && SET_FLAGS)
            flags_q <= ALU_FLAGS;
      end
   end

   // Storage needs no reset: WB_* are masked by WB_VALID, which comes from count.
   always_ff @(posedge CLK) begin
      if (push)
         mem[wr_ptr] <= in_entry;
   end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed cases plus randomized traffic
// against a queue-based reference model of the stage.
module tb_alu_wb_stage;

   localparam int DEPTH = 2;
`ifdef ALU_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk, rst;
   logic        in_valid, in_ready;
   logic [15:0] alu_out;
   logic [3:0]  alu_flags;
   logic [2:0]  rd_addr;
   logic        rd_we, set_flags, is_branch;
   logic [2:0]  cond;
   logic        wb_valid, wb_ready;
   logic [15:0] wb_data;
   logic [2:0]  wb_addr;
   logic        wb_we, br_taken;
   logic [3:0]  flags;

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  addr;
      logic        we;
      logic        br;
   } exp_t;

   exp_t       q[$];
   logic [3:0] m_flags;
   int         n_checks = 0;
   int         n_errors = 0;

   alu_wb_stage #(.DATA_W(16), .ADDR_W(3), .DEPTH(DEPTH)) dut (
      .CLK(clk), .RST(rst),
      .IN_VALID(in_valid), .IN_READY(in_ready),
      .ALU_OUT(alu_out), .ALU_FLAGS(alu_flags), .RD_ADDR(rd_addr), .RD_WE(rd_we),
      .SET_FLAGS(set_flags), .IS_BRANCH(is_branch), .COND(cond),
      .WB_VALID(wb_valid), .WB_READY(wb_ready),
      .WB_DATA(wb_data), .WB_ADDR(wb_addr), .WB_WE(wb_we), .BR_TAKEN(br_taken),
      .FLAGS(flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Condition truth table written straight from the condition-code definitions.
   function automatic bit cond_holds(input logic [3:0] f, input logic [2:0] c);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         3'd0: return 1'b1;
         3'd1: return z;
         3'd2: return !z;
         3'd3: return n != v;
         3'd4: return n == v;
         3'd5: return cy;
         3'd6: return !cy;
         default: return n;
      endcase
   endfunction

   function automatic exp_t mk_entry();
      exp_t       e;
      logic [3:0] src;
      src    = set_flags ? alu_flags : m_flags;
      e.data = alu_out;
      e.addr = rd_addr;
      e.we   = rd_we && !is_branch;
      e.br   = is_branch && cond_holds(src, cond);
      return e;
   endfunction

   task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] f,
                        input logic [2:0] a, input logic we, input logic sf,
                        input logic br, input logic [2:0] cd);
      in_valid = v; alu_out = d; alu_flags = f; rd_addr = a;
      rd_we = we; set_flags = sf; is_branch = br; cond = cd;
   endtask

   task automatic idle();
      drive(1'b0, 16'h0, 4'h0, 3'h0, 1'b0, 1'b0, 1'b0, 3'h0);
   endtask

   // One clock: compare at the falling edge, advance the model, land at posedge+1.
   task automatic cycle();
      exp_t e, hd;
      bit   hv, acc, byp;
      @(negedge clk);
      e   = mk_entry();
      hv  = (q.size() > 0) || (BYPASS && in_valid);
      hd  = (q.size() > 0) ? q[0] : e;
      check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      check("wb_valid", 32'(wb_valid), 32'(hv));
      check("flags", 32'(flags), 32'(m_flags));
      if (hv) begin
         check("wb_data", 32'(wb_data), 32'(hd.data));
         check("wb_addr", 32'(wb_addr), 32'(hd.addr));
         check("wb_we", 32'(wb_we), 32'(hd.we));
         check("br_taken", 32'(br_taken), 32'(hd.br));
      end else begin
         check("idle_data", 32'({wb_data, wb_addr, wb_we, br_taken}), 32'(0));
      end
      acc = in_valid && (q.size() < DEPTH);
      byp = BYPASS && (q.size() == 0) && in_valid && wb_ready;
      if (wb_ready && q.size() > 0) void'(q.pop_front());
      if (acc && !byp) q.push_back(e);
      if (acc && set_flags) m_flags = alu_flags;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      idle();
      rst = 1'b1;
      #2;
      check("rst_wb_valid", 32'(wb_valid), 32'(0));
      check("rst_flags", 32'(flags), 32'(0));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      m_flags = 4'h0;
      check("post_rst_in_ready", 32'(in_ready), 32'(1));
      check("post_rst_wb_valid", 32'(wb_valid), 32'(0));
      check("post_rst_flags", 32'(flags), 32'(0));
      check("post_rst_wb_data", 32'(wb_data), 32'(0));
   endtask

   initial begin
      rst = 1'b1;
      wb_ready = 1'b1;
      idle();
      m_flags = 4'h0;
      @(posedge clk);
      #1;
      reset_dut();

`ifndef ALU_WB_BYPASS_EN
      // Single result, one-cycle latency.
      wb_ready = 1'b1;
      drive(1'b1, 16'h0D4A, 4'h0, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0);
      cycle();
      idle();
      check("lat_valid", 32'(wb_valid), 32'(1));
      check("lat_data", 32'(wb_data), 32'h0D4A);
      check("lat_addr", 32'(wb_addr), 32'(3));
      check("lat_we", 32'(wb_we), 32'(1));
      cycle();

      // Z set by a flag-setting op, then EQ / NE branches on the stored flags.
      drive(1'b1, 16'h1111, 4'b0100, 3'd1, 1'b1, 1'b1, 1'b0, 3'd0);
      cycle();
      drive(1'b1, 16'h2222, 4'b0000, 3'd2, 1'b1, 1'b0, 1'b1, 3'b001);
      cycle();
      check("eq_taken", 32'(br_taken), 32'(1));
      check("eq_we", 32'(wb_we), 32'(0));
      check("eq_flags", 32'(flags), 32'b0100);
      drive(1'b1, 16'h2223, 4'b0000, 3'd2, 1'b1, 1'b0, 1'b1, 3'b010);
      cycle();
      check("ne_taken", 32'(br_taken), 32'(0));

      // Branch that also sets flags must test the new flags.
      drive(1'b1, 16'h3333, 4'b1000, 3'd4, 1'b0, 1'b1, 1'b1, 3'b011);
      cycle();
      check("lt_taken", 32'(br_taken), 32'(1));
      check("lt_flags", 32'(flags), 32'b1000);
      idle();
      cycle();

      // Backpressure: third push held until the FIFO drains, order preserved.
      wb_ready = 1'b0;
      drive(1'b1, 16'hAAAA, 4'h0, 3'd1, 1'b1, 1'b0, 1'b0, 3'd0);
      cycle();
      check("bp_ready1", 32'(in_ready), 32'(1));
      drive(1'b1, 16'hBBBB, 4'h0, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0);
      cycle();
      check("bp_ready2", 32'(in_ready), 32'(0));
      drive(1'b1, 16'hCCCC, 4'h0, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0);
      cycle();
      check("bp_held", 32'(in_ready), 32'(0));
      check("bp_head_a", 32'(wb_data), 32'hAAAA);
      wb_ready = 1'b1;
      cycle();
      check("bp_head_b", 32'(wb_data), 32'hBBBB);
      cycle();
      check("bp_head_c", 32'(wb_data), 32'hCCCC);
      check("bp_ready_pp", 32'(in_ready), 32'(1));
      idle();
      cycle();
      check("bp_drained", 32'(wb_valid), 32'(0));
`else
      // Empty FIFO with a ready consumer: result appears in the same cycle.
      wb_ready = 1'b1;
      drive(1'b1, 16'h0D4A, 4'h0, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0);
      #1;
      check("byp_valid", 32'(wb_valid), 32'(1));
      check("byp_data", 32'(wb_data), 32'h0D4A);
      check("byp_addr", 32'(wb_addr), 32'(3));
      cycle();
      idle();
      cycle();
      check("byp_not_stored", 32'(wb_valid), 32'(0));
`endif

      // Randomized traffic with one reset in the middle of the stream.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            wb_ready = 1'b0;
            drive(1'b1, 16'h5A5A, 4'hF, 3'd5, 1'b1, 1'b1, 1'b0, 3'd0);
            cycle();
            cycle();
            reset_dut();
         end
         drive(($urandom_range(0, 9) < 7), 16'($urandom), 4'($urandom),
               3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
         wb_ready = ($urandom_range(0, 9) < 6);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
